// File: rtl/cpu_bus_mem_if.sv
// cpu_bus_mem_if -- external cpu bus bundle between the cpu (master) and a
// memory slave.
//
// Signals:
//   CS             master -> slave  chip select, request valid while high
//   WR_RD          master -> slave  1 = write, 0 = read
//   ADDR           master -> slave  byte address
//   Data_BUS_WRITE master -> slave  write data
//   BE             master -> slave  byte-lane enables (only with CPU_BUS_MEM_BYTE_EN_EN)
//   Data_BUS_READ  slave -> master  read data
//   READY          slave -> master  one-cycle completion pulse
//   ERR            slave -> master  out-of-range flag, valid with READY
//   RD_CNT/WR_CNT  slave -> master  saturating completed-transaction counters
//
// Optional macro: CPU_BUS_MEM_BYTE_EN_EN adds the BE signal.
interface cpu_bus_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              CS;
  logic              WR_RD;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_BUS_WRITE;
`ifdef CPU_BUS_MEM_BYTE_EN_EN
  logic [DATA_W/8-1:0] BE;
`endif
  logic [DATA_W-1:0] Data_BUS_READ;
  logic              READY;
  logic              ERR;
  logic [15:0]       RD_CNT;
  logic [15:0]       WR_CNT;

  modport master (
`ifdef CPU_BUS_MEM_BYTE_EN_EN
    output BE,
`endif
    output CS, WR_RD, ADDR, Data_BUS_WRITE,
    input  Data_BUS_READ, READY, ERR, RD_CNT, WR_CNT
  );

  modport slave (
`ifdef CPU_BUS_MEM_BYTE_EN_EN
    input  BE,
`endif
    input  CS, WR_RD, ADDR, Data_BUS_WRITE,
    output Data_BUS_READ, READY, ERR, RD_CNT, WR_CNT
  );
endinterface

// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem -- word-addressed RAM slave for the cpu external bus with
// programmable wait states, a READY pulse, an out-of-range ERR flag and
// saturating read/write counters.
//
// Ports:
//   CLK  in   system clock, all state changes on the rising edge
//   rst  in   synchronous active-high reset (does not clear the RAM)
//   bus  slave modport of cpu_bus_mem_if (CS, WR_RD, ADDR, Data_BUS_WRITE,
//        [BE], Data_BUS_READ, READY, ERR, RD_CNT, WR_CNT)
//
// Optional macro: CPU_BUS_MEM_BYTE_EN_EN -- when defined, writes only update
// the byte lanes whose latched BE bit is set; reads ignore BE.
module cpu_bus_mem #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
  parameter int                WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] FILL        = 32'hAAAA_AAAA
) (
  input  logic         CLK,
  input  logic         rst,
  cpu_bus_mem_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  // Address window size in bytes; one bit wider than ADDR so it never wraps.
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_wait;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
`ifdef CPU_BUS_MEM_BYTE_EN_EN
  logic [BYTES-1:0]  r_be;
`endif
  logic              r_ready;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic [15:0]       r_rd_cnt;
  logic [15:0]       r_wr_cnt;

  // RAM starts out filled with FILL; reset deliberately leaves it untouched.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: FILL};

  logic [ADDR_W-1:0] w_offset;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_mem_we;

  // Range is judged on the latched address: below base, or offset past the
  // window, is out of range. Low byte-offset bits fall out of the index.
  assign w_offset   = r_addr - BASE_ADDR;
  assign w_in_range = (r_addr >= BASE_ADDR) && ({1'b0, w_offset} < SPAN);
  assign w_idx      = w_offset[OFS +: IDX_W];
  // A write lands only when leaving RESP without a reset on the same edge.
  assign w_mem_we   = !rst && (r_state == RESP) && r_wr && w_in_range;

  // RAM write port.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
`ifdef CPU_BUS_MEM_BYTE_EN_EN
      for (int b = 0; b < BYTES; b++) begin
        if (r_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= r_data[8*b +: 8];
        end
      end
`else
      r_mem[w_idx] <= r_data;
`endif
    end
  end

  // Transaction FSM: latch request, count wait states, respond, then wait
  // for CS to drop so a held CS never starts a second transaction.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wait   <= 4'd0;
      r_wr     <= 1'b0;
      r_addr   <= {ADDR_W{1'b0}};
      r_data   <= {DATA_W{1'b0}};
`ifdef CPU_BUS_MEM_BYTE_EN_EN
      r_be     <= {BYTES{1'b0}};
`endif
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= {DATA_W{1'b0}};
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else begin
      // READY/ERR are pulses; only RESP raises them.
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.CS) begin
            r_wr   <= bus.WR_RD;
            r_addr <= bus.ADDR;
            r_data <= bus.Data_BUS_WRITE;
`ifdef CPU_BUS_MEM_BYTE_EN_EN
            r_be   <= bus.BE;
`endif
            if (WAIT_STATES > 0) begin
              r_state <= WAIT;
              r_wait  <= 4'(WAIT_STATES - 1);
            end else begin
              r_state <= RESP;
            end
          end
        end
        WAIT: begin
          // Loaded with WAIT_STATES-1, so WAIT lasts WAIT_STATES cycles.
          if (r_wait == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        RESP: begin
          r_ready <= 1'b1;
          r_err   <= !w_in_range;
          if (r_wr) begin
            if (r_wr_cnt != 16'hFFFF) begin
              r_wr_cnt <= r_wr_cnt + 16'd1;
            end
          end else begin
            r_rdata <= w_in_range ? r_mem[w_idx] : FILL;
            if (r_rd_cnt != 16'hFFFF) begin
              r_rd_cnt <= r_rd_cnt + 16'd1;
            end
          end
          r_state <= HOLD;
        end
        HOLD: begin
          if (!bus.CS) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Data_BUS_READ = r_rdata;
  assign bus.READY         = r_ready;
  assign bus.ERR           = r_err;
  assign bus.RD_CNT        = r_rd_cnt;
  assign bus.WR_CNT        = r_wr_cnt;

endmodule

// File: tb/tb_cpu_bus_mem.sv
// tb_cpu_bus_mem -- self-checking bench for cpu_bus_mem: directed scenarios
// with literal expectations followed by randomized transactions, all
// compared each cycle against a transaction-level reference model.
module tb_cpu_bus_mem;
  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 256;
  localparam int          WS    = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] FILLV = 32'hAAAA_AAAA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_bus_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  cpu_bus_mem #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .WAIT_STATES(WS), .FILL(FILLV)
  ) dut (
    .CLK(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level, timestamp based)
  logic [31:0] m_mem [DEPTH];
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;
  bit          m_drop  = 1'b0;
  longint      m_cyc   = 0;
  longint      m_done  = 0;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_be;
  logic        e_ready = 1'b0;
  logic        e_err   = 1'b0;
  logic [31:0] e_rdata = 32'h0;
  int          e_rd    = 0;
  int          e_wr    = 0;

  initial foreach (m_mem[i]) m_mem[i] = FILLV;

  function automatic bit in_rng(input logic [31:0] a);
    longint la = longint'(a);
    longint lb = longint'(BASE);
    return (la >= lb) && (la < lb + longint'(DEPTH) * 4);
  endfunction

  always @(posedge clk) begin
    int idx;
    m_cyc++;
    if (rst) begin
      m_valid = 1'b1; m_pend = 1'b0; m_drop = 1'b0;
      e_ready = 1'b0; e_err = 1'b0; e_rdata = 32'h0; e_rd = 0; e_wr = 0;
    end else begin
      e_ready = 1'b0;
      e_err   = 1'b0;
      if (m_pend && m_cyc == m_done) begin
        e_ready = 1'b1;
        e_err   = !in_rng(m_addr);
        idx     = int'((longint'(m_addr) - longint'(BASE)) / 4);
        if (m_wr) begin
          if (in_rng(m_addr)) begin
`ifdef CPU_BUS_MEM_BYTE_EN_EN
            for (int b = 0; b < 4; b++)
              if (m_be[b]) m_mem[idx][8*b +: 8] = m_data[8*b +: 8];
`else
            m_mem[idx] = m_data;
`endif
          end
          if (e_wr < 65535) e_wr++;
        end else begin
          e_rdata = in_rng(m_addr) ? m_mem[idx] : FILLV;
          if (e_rd < 65535) e_rd++;
        end
        m_pend = 1'b0;
        m_drop = 1'b1;
      end else if (m_drop) begin
        if (!bus.CS) m_drop = 1'b0;
      end else if (!m_pend && bus.CS) begin
        m_wr   = bus.WR_RD;
        m_addr = bus.ADDR;
        m_data = bus.Data_BUS_WRITE;
`ifdef CPU_BUS_MEM_BYTE_EN_EN
        m_be   = bus.BE;
`else
        m_be   = 4'hF;
`endif
        m_pend = 1'b1;
        m_done = m_cyc + 1 + WS;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready",  {31'h0, bus.READY}, {31'h0, e_ready});
      check("err",    {31'h0, bus.ERR},   {31'h0, e_err});
      check("rdata",  bus.Data_BUS_READ,  e_rdata);
      check("rd_cnt", {16'h0, bus.RD_CNT}, 32'(e_rd));
      check("wr_cnt", {16'h0, bus.WR_CNT}, 32'(e_wr));
    end
  end

  // ---------------- stimulus
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] be, input int hold, input bit early_drop,
                     input bit abort, input int abort_at,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output int n_extra);
    bit got = 1'b0;
    int lim;
    @(negedge clk);
    bus.CS = 1'b1; bus.WR_RD = wr; bus.ADDR = addr; bus.Data_BUS_WRITE = data;
`ifdef CPU_BUS_MEM_BYTE_EN_EN
    bus.BE = be;
`else
    if (be == 4'h0) lim = 0;
`endif
    lat = -1; rdata = 32'h0; err = 1'b0; n_extra = 0;
    lim = abort ? abort_at + 4 : 20;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (bus.READY) begin
        got = 1'b1; lat = i; rdata = bus.Data_BUS_READ; err = bus.ERR;
      end
      if (i == 0) begin
        // Post-latch changes must be ignored.
        bus.ADDR = $urandom; bus.Data_BUS_WRITE = $urandom; bus.WR_RD = 1'($urandom);
        if (early_drop) bus.CS = 1'b0;
      end
      if (abort && i == abort_at) begin rst = 1'b1; bus.CS = 1'b0; end
      if (abort && i == abort_at + 1) rst = 1'b0;
    end
    if (!abort) check("ready_seen", {31'h0, got}, 32'h1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.READY) n_extra++;
    end
    bus.CS = 1'b0; bus.ADDR = $urandom;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nx;
    bus.CS = 1'b0; bus.WR_RD = 1'b0; bus.ADDR = 32'h0; bus.Data_BUS_WRITE = 32'h0;
`ifdef CPU_BUS_MEM_BYTE_EN_EN
    bus.BE = 4'h0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_ready", {31'h0, bus.READY}, 32'h0);
    check("rst_err",   {31'h0, bus.ERR},   32'h0);
    check("rst_rdcnt", {16'h0, bus.RD_CNT}, 32'h0);
    check("rst_wrcnt", {16'h0, bus.WR_CNT}, 32'h0);
    check("rst_rdata", bus.Data_BUS_READ,  32'h0);

    // Read with CS held high: single READY, 3 edges after latch.
    txn(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("t2_lat",   32'(lat), 32'd3);
    check("t2_data",  rd, 32'hAAAA_AAAA);
    check("t2_err",   {31'h0, er}, 32'h0);
    check("t2_rdcnt", {16'h0, bus.RD_CNT}, 32'd1);
    check("t2_extra", 32'(nx), 32'd0);

    // Write then read back; neighbour word untouched.
    txn(1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("t3_werr", {31'h0, er}, 32'h0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("t3_data",  rd, 32'h1234_5678);
    check("t3_wrcnt", {16'h0, bus.WR_CNT}, 32'd1);
    check("t3_rdcnt", {16'h0, bus.RD_CNT}, 32'd2);
    txn(1'b0, 32'h24, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("t3_nbr", rd, 32'hAAAA_AAAA);

    // Out-of-range write: ERR with READY, RAM unchanged.
    txn(1'b1, 32'h400, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("t4_err", {31'h0, er}, 32'h1);
    check("t4_lat", 32'(lat), 32'd3);
    txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("t4_data",  rd, 32'hAAAA_AAAA);
    check("t4_wrcnt", {16'h0, bus.WR_CNT}, 32'd2);

    // Reset during WAIT aborts the write.
    txn(1'b1, 32'h8, 32'h55, 4'hF, 0, 1'b0, 1'b1, 1, rd, er, lat, nx);
    check("t5_noready", 32'(lat), 32'hFFFF_FFFF);
    check("t5_rdcnt", {16'h0, bus.RD_CNT}, 32'd0);
    check("t5_wrcnt", {16'h0, bus.WR_CNT}, 32'd0);
    txn(1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("t5_data", rd, 32'hAAAA_AAAA);

`ifdef CPU_BUS_MEM_BYTE_EN_EN
    txn(1'b1, 32'h0, 32'h1122_3344, 4'b0101, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("be_data", rd, 32'hAA22_AA44);
    txn(1'b1, 32'h4, 32'h9999_9999, 4'b0000, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("be0_err", {31'h0, er}, 32'h0);
    txn(1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0, rd, er, lat, nx);
    check("be0_data", rd, 32'hAAAA_AAAA);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 120; k++) begin
      bit          wr    = 1'($urandom_range(0, 1));
      int          sel   = int'($urandom_range(0, 9));
      logic [31:0] a;
      bit          early = ($urandom_range(0, 3) == 0);
      bit          ab    = ($urandom_range(0, 9) == 0);
      int          ab_at = int'($urandom_range(1, 2));
      int          hold  = int'($urandom_range(0, 3));
      if (sel == 0)      a = 32'h400 + 32'(4 * $urandom_range(0, 64));
      else if (sel == 1) a = $urandom;
      else               a = 32'(4 * $urandom_range(0, 15));
      a = a | 32'($urandom_range(0, 3));
      txn(wr, a, $urandom, 4'($urandom_range(0, 15)), hold, early, ab, ab_at,
          rd, er, lat, nx);
      if (!ab) begin
        check("rnd_lat",   32'(lat), 32'd3);
        check("rnd_extra", 32'(nx),  32'd0);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
